// File: rtl/func_lut_pkg.sv
// Shared types and arithmetic for the activation-function LUT scheduler.
// The interpolation helper works at the default 8/4/4 datapath widths.
package func_lut_pkg;

    localparam int unsigned LUT_DATA_W = 8;
    localparam int unsigned LUT_ADDR_W = 4;
    localparam int unsigned LUT_FRAC_W = 4;
    localparam int unsigned LUT_PROD_W = LUT_DATA_W + LUT_FRAC_W + 1;

    typedef enum logic [1:0] {
        StIdle,
        StLookup,
        StInterp,
        StResp
    } state_e;

    // y = base + floor(diff * frac / 2^FRAC_W); the result always lies between base and next.
    function automatic logic signed [LUT_DATA_W-1:0] interp(
        input logic signed [LUT_DATA_W-1:0] base,
        input logic signed [LUT_DATA_W:0]   diff,
        input logic        [LUT_FRAC_W-1:0] frac
    );
        logic signed [LUT_PROD_W-1:0] prod;
        logic signed [LUT_PROD_W-1:0] sum;
        prod = $signed({{(LUT_PROD_W-LUT_DATA_W-1){diff[LUT_DATA_W]}}, diff})
             * $signed({{(LUT_PROD_W-LUT_FRAC_W){1'b0}}, frac});
        sum  = $signed({{(LUT_PROD_W-LUT_DATA_W){base[LUT_DATA_W-1]}}, base})
             + (prod >>> LUT_FRAC_W);
        return LUT_DATA_W'(sum);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or after ptr, cyclically.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             any
);

    always_comb begin : arb
        int unsigned idx;
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = (32'(ptr) + i) % N_REQ;
            if (!any && req[ID_W'(idx)]) begin
                any              = 1'b1;
                gnt[ID_W'(idx)]  = 1'b1;
                gnt_id           = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/func_lut_scheduler.sv
// Shares one external combinational activation LUT between N_REQ neurons: round-robin grant,
// registered LUT lookup, linear interpolation and a valid/ready result return.
module func_lut_scheduler
    import func_lut_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned ID_W   = 2,
    parameter int unsigned DATA_W = LUT_DATA_W,
    parameter int unsigned ADDR_W = LUT_ADDR_W,
    parameter int unsigned FRAC_W = LUT_FRAC_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DATA_W-1:0]    req_x,
    output logic [N_REQ-1:0]           req_ack,
    output logic [ADDR_W-1:0]          lut_addr,
    input  logic signed [DATA_W-1:0]   lut_base,
    input  logic signed [DATA_W-1:0]   lut_next,
    output logic                       resp_valid,
    output logic [ID_W-1:0]            resp_id,
    output logic signed [DATA_W-1:0]   resp_y,
    input  logic                       resp_ready,
    output logic                       busy
);

    state_e                    state_q, state_d;
    logic [ID_W-1:0]           ptr_q;
    logic [ID_W-1:0]           id_q;
    logic [FRAC_W-1:0]         frac_q;
    logic [ADDR_W-1:0]         lut_addr_q;
    logic signed [DATA_W-1:0]  base_q;
    logic signed [DATA_W:0]    diff_q;
    logic                      resp_valid_q;
    logic [ID_W-1:0]           resp_id_q;
    logic signed [DATA_W-1:0]  resp_y_q;

    logic [N_REQ-1:0]          gnt;
    logic [ID_W-1:0]           gnt_id;
    logic                      gnt_any;
    logic [DATA_W-1:0]         sel_x;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (gnt_any)
    );

    always_comb begin
        sel_x = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (gnt[i]) sel_x = req_x[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (gnt_any) state_d = StLookup;
            StLookup: state_d = StInterp;
            StInterp: state_d = StResp;
            StResp:   if (resp_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            id_q         <= '0;
            frac_q       <= '0;
            lut_addr_q   <= '0;
            base_q       <= '0;
            diff_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_y_q     <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (gnt_any) begin
                        ptr_q      <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
                        id_q       <= gnt_id;
                        lut_addr_q <= sel_x[DATA_W-1 -: ADDR_W];
                        frac_q     <= sel_x[FRAC_W-1:0];
                    end
                end
                StLookup: begin
                    base_q <= lut_base;
                    diff_q <= {lut_next[DATA_W-1], lut_next} - {lut_base[DATA_W-1], lut_base};
                end
                StInterp: begin
                    resp_y_q     <= interp(base_q, diff_q, frac_q);
                    resp_id_q    <= id_q;
                    resp_valid_q <= 1'b1;
                end
                StResp: begin
                    if (resp_ready) resp_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Ack is the live grant so the requester sees it in the cycle its input is captured.
    assign req_ack    = (state_q == StIdle && !rst) ? gnt : '0;
    assign lut_addr   = lut_addr_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_y     = resp_y_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_func_lut_scheduler.sv
// Directed bench for func_lut_scheduler: vector table of single transactions plus
// round-robin, back-pressure and mid-operation reset sequences.
module tb_func_lut_scheduler;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        req;
    logic [31:0]       req_x;
    logic [3:0]        req_ack;
    logic [3:0]        lut_addr;
    logic signed [7:0] lut_base;
    logic signed [7:0] lut_next;
    logic              resp_valid;
    logic [1:0]        resp_id;
    logic signed [7:0] resp_y;
    logic              resp_ready;
    logic              busy;

    logic              use_stub;
    logic signed [7:0] stub_base;
    logic signed [7:0] stub_next;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    func_lut_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_x      (req_x),
        .req_ack    (req_ack),
        .lut_addr   (lut_addr),
        .lut_base   (lut_base),
        .lut_next   (lut_next),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_y     (resp_y),
        .resp_ready (resp_ready),
        .busy       (busy)
    );

    // Activation table: 0,16,...,112 then zeros; entry 7 is its own successor, 15 wraps to 0.
    function automatic logic signed [7:0] tab(input int a);
        return (a < 8) ? 8'(a * 16) : 8'sd0;
    endfunction

    always_comb begin
        if (use_stub) begin
            lut_base = stub_base;
            lut_next = stub_next;
        end else begin
            lut_base = tab(int'(lut_addr));
            lut_next = (lut_addr == 4'd7) ? tab(7) : tab((int'(lut_addr) + 1) % 16);
        end
    end

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called just after a negedge; returns granted index (-1 on timeout) and cycles waited.
    task automatic wait_ack(output int idx, output int waited);
        waited = 0;
        idx    = -1;
        while (req_ack == 4'b0 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        for (int i = 0; i < 4; i++) if (req_ack[i]) idx = i;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_txn(input int id, input logic [7:0] x, input int exp_y, input string tag);
        int idx, waited;
        @(negedge clk);
        req = '0;
        req[id] = 1'b1;
        req_x[id*8 +: 8] = x;
        #1;
        wait_ack(idx, waited);
        chk({tag, ".ack"}, 32'(req_ack), 32'(1 << id));
        @(negedge clk);
        req = '0;
        #1;
        chk({tag, ".addr"}, 32'(lut_addr), 32'(x[7:4]));
        chk({tag, ".busy"}, 32'(busy), 1);
        @(negedge clk);
        #1;
        chk({tag, ".early_valid"}, 32'(resp_valid), 0);
        @(negedge clk);
        #1;
        chk({tag, ".valid"}, 32'(resp_valid), 1);
        chk({tag, ".id"}, 32'(resp_id), id);
        chk({tag, ".y"}, 32'(resp_y), exp_y);
        @(negedge clk);
        #1;
        chk({tag, ".drop_valid"}, 32'(resp_valid), 0);
    endtask

    typedef struct {
        logic       stub;
        int         sbase;
        int         snext;
        int         id;
        logic [7:0] x;
        int         y;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int idx, waited, t;
        int exp_order[8];

        vecs[0] = '{1'b0,    0,    0, 1, 8'h25,  37};
        vecs[1] = '{1'b0,    0,    0, 0, 8'h7F, 112};
        vecs[2] = '{1'b0,    0,    0, 2, 8'hF8,   0};
        vecs[3] = '{1'b1, -100,   20, 3, 8'h03, -78};
        vecs[4] = '{1'b1, -100,   20, 0, 8'h50, -100};
        vecs[5] = '{1'b0,    0,    0, 3, 8'h6C, 108};
        vecs[6] = '{1'b0,    0,    0, 2, 8'h48,  72};
        vecs[7] = '{1'b1, -100,   20, 1, 8'h0F,  12};
        vecs[8] = '{1'b1,   20, -100, 2, 8'hA3,  -3};

        exp_order = '{0, 2, 0, 2, 3, 0, 1, 2};

        rst        = 1'b1;
        req        = 4'b1111;
        req_x      = '0;
        resp_ready = 1'b1;
        use_stub   = 1'b0;
        stub_base  = '0;
        stub_next  = '0;

        // Reset state, with requests pending to show reset masks the ack.
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst.ack", 32'(req_ack), 0);
        chk("rst.valid", 32'(resp_valid), 0);
        chk("rst.id", 32'(resp_id), 0);
        chk("rst.y", 32'(resp_y), 0);
        chk("rst.addr", 32'(lut_addr), 0);
        chk("rst.busy", 32'(busy), 0);
        req = '0;
        rst = 1'b0;

        for (int v = 0; v < 9; v++) begin
            @(negedge clk);
            use_stub  = vecs[v].stub;
            stub_base = 8'(vecs[v].sbase);
            stub_next = 8'(vecs[v].snext);
            do_txn(vecs[v].id, vecs[v].x, vecs[v].y, $sformatf("vec%0d", v));
        end
        use_stub = 1'b0;

        // Round robin: continuous 0101 from pointer 0, then 1111 from pointer 3.
        do_reset();
        @(negedge clk);
        req_x = {4{8'h25}};
        req   = 4'b0101;
        #1;
        for (int k = 0; k < 8; k++) begin
            wait_ack(idx, waited);
            chk($sformatf("rr.grant%0d", k), idx, exp_order[k]);
            if (k > 0) chk($sformatf("rr.gap%0d", k), waited, 3);
            @(negedge clk);
            if (k == 3) req = 4'b1111;
            if (k == 7) req = 4'b0000;
            #1;
        end
        repeat (5) @(negedge clk);

        // Back-pressure: result held for 5 stalled cycles while neuron 0 waits.
        resp_ready = 1'b0;
        req = 4'b0100;
        #1;
        wait_ack(idx, waited);
        chk("bp.grant", idx, 2);
        @(negedge clk);
        req = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp.valid%0d", c), 32'(resp_valid), 1);
            chk($sformatf("bp.y%0d", c), 32'(resp_y), 37);
            chk($sformatf("bp.id%0d", c), 32'(resp_id), 2);
            chk($sformatf("bp.noack%0d", c), 32'(req_ack), 0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        #1;
        chk("bp.hs_valid", 32'(resp_valid), 1);
        chk("bp.hs_noack", 32'(req_ack), 0);
        @(negedge clk);
        #1;
        chk("bp.after_valid", 32'(resp_valid), 0);
        chk("bp.after_busy", 32'(busy), 0);
        chk("bp.next_ack", 32'(req_ack), 32'(4'b0001));
        @(negedge clk);
        req = '0;
        repeat (6) @(negedge clk);

        // Reset during INTERP after moving the pointer past 0.
        do_txn(1, 8'h25, 37, "pre");
        @(negedge clk);
        req = 4'b1000;
        #1;
        wait_ack(idx, waited);
        chk("mid.grant", idx, 3);
        @(negedge clk);
        req = '0;
        @(negedge clk);
        #1;
        chk("mid.busy_interp", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mid.valid", 32'(resp_valid), 0);
        chk("mid.y", 32'(resp_y), 0);
        chk("mid.id", 32'(resp_id), 0);
        chk("mid.addr", 32'(lut_addr), 0);
        chk("mid.busy", 32'(busy), 0);
        chk("mid.ack", 32'(req_ack), 0);
        rst = 1'b0;
        req = 4'b1111;
        #1;
        t = 0;
        wait_ack(idx, t);
        chk("mid.first_grant", idx, 0);
        @(negedge clk);
        req = '0;
        #1;
        chk("mid.no_stale_valid", 32'(resp_valid), 0);
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
